// File: rtl/pc_fetch_unit_pkg.sv
// rtl/pc_fetch_unit_pkg.sv - shared constants and FSM state type for the PC fetch unit
package pc_fetch_unit_pkg;

   localparam int ADDR_W = 16;
   localparam logic [ADDR_W-1:0] RESET_VECTOR_DEFAULT = 16'h0000;
   localparam logic [ADDR_W-1:0] PC_INCR = 16'd1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_OUT   = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit_instr_fifo.sv
// rtl/pc_fetch_unit_instr_fifo.sv - 2-entry instruction/PC FIFO with flush, used by the prefetch build
module instr_fifo #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic [W-1:0] push_pc,
   input  logic         pop,
   output logic [1:0]   level,
   output logic         empty,
   output logic         full,
   output logic [W-1:0] head_data,
   output logic [W-1:0] head_pc
);

   logic [W-1:0] data_q [2];
   logic [W-1:0] data_d [2];
   logic [W-1:0] pc_q [2];
   logic [W-1:0] pc_d [2];
   logic         rd_ptr_q, rd_ptr_d;
   logic         wr_ptr_q, wr_ptr_d;
   logic [1:0]   count_q, count_d;
   logic         do_push, do_pop;

   always_comb begin
      data_d   = data_q;
      pc_d     = pc_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      do_pop   = pop && (count_q != 2'd0);
      do_push  = push && ((count_q != 2'd2) || do_pop);
      if (flush) begin
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (do_push) begin
            data_d[wr_ptr_q] = push_data;
            pc_d[wr_ptr_q]   = push_pc;
            wr_ptr_d         = ~wr_ptr_q;
         end
         if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         count_d = count_q + 2'(do_push) - 2'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_q   <= '{default: '0};
         pc_q     <= '{default: '0};
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         data_q   <= data_d;
         pc_q     <= pc_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign level     = count_q;
   assign empty     = (count_q == 2'd0);
   assign full      = (count_q == 2'd2);
   assign head_data = data_q[rd_ptr_q];
   assign head_pc   = pc_q[rd_ptr_q];

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC register, imem request FSM and decode handoff; adder is external
// PC_FETCH_PREFETCH_EN adds a 2-entry instruction FIFO for back-to-back fetching.
module pc_fetch_unit
   import pc_fetch_unit_pkg::*;
#(
   parameter int                ADDR_W       = pc_fetch_unit_pkg::ADDR_W,
   parameter logic [ADDR_W-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] add_a,
   output logic [ADDR_W-1:0] add_b,
   input  logic [ADDR_W-1:0] add_sum,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [ADDR_W-1:0] imem_rdata,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [ADDR_W-1:0] instr_data,
   output logic [ADDR_W-1:0] instr_pc,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_off
);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] req_addr_q, req_addr_d;

   assign add_a = pc_q;
   assign add_b = redirect ? redirect_off : ADDR_W'(PC_INCR);

`ifdef PC_FETCH_PREFETCH_EN
   logic              fifo_push, fifo_pop, fifo_empty, fifo_full;
   logic [1:0]        fifo_level;
   logic [ADDR_W-1:0] fifo_data, fifo_pc;

   instr_fifo #(.W(ADDR_W)) u_instr_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (redirect),
      .push      (fifo_push),
      .push_data (imem_rdata),
      .push_pc   (pc_q),
      .pop       (fifo_pop),
      .level     (fifo_level),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .head_data (fifo_data),
      .head_pc   (fifo_pc)
   );

   assign instr_valid = !fifo_empty;
   assign instr_data  = fifo_data;
   assign instr_pc    = fifo_pc;
   assign fifo_pop    = instr_valid && instr_ready && !redirect;
`else
   logic              instr_valid_q, instr_valid_d;
   logic [ADDR_W-1:0] instr_data_q, instr_data_d;
   logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;

   assign instr_valid = instr_valid_q;
   assign instr_data  = instr_data_q;
   assign instr_pc    = instr_pc_q;
`endif

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_addr_d = req_addr_q;
      imem_req   = 1'b0;
      imem_addr  = pc_q;
`ifdef PC_FETCH_PREFETCH_EN
      fifo_push  = 1'b0;
`else
      instr_valid_d = instr_valid_q;
      instr_data_d  = instr_data_q;
      instr_pc_d    = instr_pc_q;
`endif
      unique case (state_q)
         ST_IDLE: state_d = ST_REQ;
         ST_REQ: begin
            imem_req   = 1'b1;
            imem_addr  = pc_q;
            req_addr_d = pc_q;
            // A redirect poisons this request; DRAIN waits out its ack on the old address.
            if (redirect) begin
               state_d = imem_ack ? ST_REQ : ST_DRAIN;
            end else if (imem_ack) begin
               pc_d = add_sum;
`ifdef PC_FETCH_PREFETCH_EN
               fifo_push = 1'b1;
               if ((fifo_level == 2'd1) && !fifo_pop) begin
                  state_d = ST_OUT;
               end
`else
               instr_valid_d = 1'b1;
               instr_data_d  = imem_rdata;
               instr_pc_d    = pc_q;
               state_d       = ST_OUT;
`endif
            end
         end
         ST_DRAIN: begin
            imem_req  = 1'b1;
            imem_addr = req_addr_q;
            if (imem_ack) begin
               state_d = ST_REQ;
            end
         end
         ST_OUT: begin
`ifdef PC_FETCH_PREFETCH_EN
            if (redirect || !fifo_full) begin
               state_d = ST_REQ;
            end
`else
            if (redirect || instr_ready) begin
               instr_valid_d = 1'b0;
               state_d       = ST_REQ;
            end
`endif
         end
         default: state_d = ST_IDLE;
      endcase
      if (redirect) begin
         pc_d = add_sum;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         pc_q       <= RESET_VECTOR;
         req_addr_q <= RESET_VECTOR;
`ifndef PC_FETCH_PREFETCH_EN
         instr_valid_q <= 1'b0;
         instr_data_q  <= '0;
         instr_pc_q    <= '0;
`endif
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_addr_q <= req_addr_d;
`ifndef PC_FETCH_PREFETCH_EN
         instr_valid_q <= instr_valid_d;
         instr_data_q  <= instr_data_d;
         instr_pc_q    <= instr_pc_d;
`endif
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - randomized bench for pc_fetch_unit with a transaction-level fetch model
module tb_pc_fetch_unit;

   localparam logic [15:0] RV = 16'h0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] add_a, add_b, add_sum;
   logic        imem_req, imem_ack = 1'b0;
   logic [15:0] imem_addr, imem_rdata = '0;
   logic        instr_valid, instr_ready = 1'b0;
   logic [15:0] instr_data, instr_pc;
   logic        redirect = 1'b0;
   logic [15:0] redirect_off = '0;

   assign add_sum = add_a + add_b;

   pc_fetch_unit #(.ADDR_W(16), .RESET_VECTOR(RV)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .add_a        (add_a),
      .add_b        (add_b),
      .add_sum      (add_sum),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ack     (imem_ack),
      .imem_rdata   (imem_rdata),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .instr_data   (instr_data),
      .instr_pc     (instr_pc),
      .redirect     (redirect),
      .redirect_off (redirect_off)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: architectural PC, instructions owed to decode, one outstanding memory request.
   logic [15:0] m_pc;
   logic [15:0] owed[$];
   logic [15:0] req_log[$];
   logic [15:0] req_addr;
   bit          pending, clean, first_cycle, late_ack;
   int          ack_wait, ack_lo, ack_hi;

   function automatic logic [15:0] memf(input logic [15:0] a);
      logic [31:0] p;
      p = a * 32'h0000_9E37;
      return p[15:0] ^ 16'h5A5A;
   endfunction

   task automatic tick(input bit rd, input logic [15:0] off, input bit rdy);
      bit ack, xfer, req_now;
      checks++;
      if (add_a !== m_pc) begin
         errors++; $display("FAIL add_a got %h exp %h", add_a, m_pc);
      end
      checks++;
      if (imem_req !== (owed.size() == 0 && !first_cycle)) begin
         errors++; $display("FAIL imem_req got %b exp %b", imem_req, (owed.size() == 0 && !first_cycle));
      end
      checks++;
      if (instr_valid !== (owed.size() != 0)) begin
         errors++; $display("FAIL instr_valid got %b exp %b", instr_valid, owed.size() != 0);
      end
      if (owed.size() != 0) begin
         checks++;
         if (instr_pc !== owed[0] || instr_data !== memf(owed[0])) begin
            errors++; $display("FAIL instr got pc %h data %h exp pc %h data %h", instr_pc, instr_data, owed[0], memf(owed[0]));
         end
      end
      ack = 1'b0;
      req_now = (imem_req === 1'b1);
      if (req_now) begin
         if (!pending) begin
            checks++;
            if (imem_addr !== m_pc) begin
               errors++; $display("FAIL req_addr got %h exp %h", imem_addr, m_pc);
            end
            req_log.push_back(imem_addr);
            req_addr = m_pc;
            pending  = 1'b1;
            clean    = 1'b1;
            ack_wait = $urandom_range(ack_hi, ack_lo);
         end else begin
            checks++;
            if (imem_addr !== req_addr) begin
               errors++; $display("FAIL req_stable got %h exp %h", imem_addr, req_addr);
            end
         end
         ack = (ack_wait == 0);
         if (!ack) ack_wait--;
      end
      if (late_ack) begin
         ack = 1'b1;
         late_ack = 1'b0;
      end
      imem_ack     = ack;
      imem_rdata   = (ack && req_now) ? memf(req_addr) : 16'($urandom);
      redirect     = rd;
      redirect_off = off;
      instr_ready  = rdy;
      xfer = (owed.size() != 0) && rdy && !rd;
      if (xfer) void'(owed.pop_front());
      if (rd) begin
         m_pc = m_pc + off;
         owed.delete();
         clean = 1'b0;
      end
      if (req_now && ack) begin
         if (clean) begin
            owed.push_back(req_addr);
            m_pc = m_pc + 16'd1;
         end
         pending = 1'b0;
      end
      first_cycle = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset(input bit late);
      rst_n        = 1'b0;
      redirect     = 1'b1;
      redirect_off = 16'($urandom);
      imem_ack     = 1'b1;
      imem_rdata   = 16'($urandom);
      instr_ready  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      redirect = 1'b0;
      imem_ack = 1'b0;
      #1;
      checks++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
         errors++; $display("FAIL reset_ctrl got req %b valid %b exp 0 0", imem_req, instr_valid);
      end
      checks++;
      if (instr_data !== 16'h0 || instr_pc !== 16'h0) begin
         errors++; $display("FAIL reset_regs got data %h pc %h exp 0000 0000", instr_data, instr_pc);
      end
      checks++;
      if (add_a !== RV) begin
         errors++; $display("FAIL reset_pc got %h exp %h", add_a, RV);
      end
      rst_n = 1'b1;
      m_pc = RV;
      owed.delete();
      pending = 1'b0;
      clean = 1'b0;
      first_cycle = 1'b1;
      late_ack = late;
   endtask

   task automatic reach_out();
      int n = 0;
      while (owed.size() == 0 && n < 30) begin
         tick(1'b0, 16'h0, 1'b0);
         n++;
      end
      checks++;
      if (owed.size() == 0) begin
         errors++; $display("FAIL reach_out timeout got %0d cycles exp <30", n);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      do_reset(1'b0);
   endtask

   task automatic test_sequential();
      int n = 0;
      logic [15:0] exp_addr;
      ack_lo = 1; ack_hi = 1;
      req_log.delete();
      while (req_log.size() < 3 && n < 40) begin
         tick(1'b0, 16'h0, 1'b1);
         n++;
      end
      for (int i = 0; i < 3; i++) begin
         exp_addr = 16'(i);
         checks++;
         if (req_log.size() <= i || req_log[i] !== exp_addr) begin
            errors++; $display("FAIL seq_addr%0d got %h exp %h", i, (req_log.size() > i) ? req_log[i] : 16'hxxxx, exp_addr);
         end
      end
   endtask

   task automatic test_wrap();
      int n = 0;
      ack_lo = 1; ack_hi = 1;
      tick(1'b1, 16'hFFFF - m_pc, 1'b1);
      req_log.delete();
      while (req_log.size() < 2 && n < 40) begin
         tick(1'b0, 16'h0, 1'b1);
         n++;
      end
      checks++;
      if (req_log.size() < 2 || req_log[0] !== 16'hFFFF || req_log[1] !== 16'h0000) begin
         errors++; $display("FAIL wrap got %0d reqs first %h second %h exp FFFF 0000", req_log.size(),
                            (req_log.size() > 0) ? req_log[0] : 16'hxxxx, (req_log.size() > 1) ? req_log[1] : 16'hxxxx);
      end
   endtask

   task automatic test_redirect_out();
      int n = 0;
      ack_lo = 1; ack_hi = 1;
      reach_out();
      tick(1'b1, 16'h0010 - m_pc, 1'b0);
      reach_out();
      checks++;
      if (instr_pc !== 16'h0010 || add_a !== 16'h0011) begin
         errors++; $display("FAIL out_setup got pc %h instr_pc %h exp 0011 0010", add_a, instr_pc);
      end
      tick(1'b1, 16'hFFF0, 1'b1);
      checks++;
      if (instr_valid !== 1'b0) begin
         errors++; $display("FAIL out_redirect_valid got %b exp 0", instr_valid);
      end
      req_log.delete();
      while (req_log.size() < 1 && n < 10) begin
         tick(1'b0, 16'h0, 1'b0);
         n++;
      end
      checks++;
      if (req_log.size() < 1 || req_log[0] !== 16'h0001) begin
         errors++; $display("FAIL out_redirect_addr got %h exp 0001", (req_log.size() > 0) ? req_log[0] : 16'hxxxx);
      end
   endtask

   task automatic test_redirect_drain();
      int n = 0;
      bit saw_valid = 1'b0;
      ack_lo = 1; ack_hi = 1;
      reach_out();
      tick(1'b1, 16'h0005 - m_pc, 1'b0);
      ack_lo = 3; ack_hi = 3;
      req_log.delete();
      tick(1'b1, 16'h0020, 1'b0);
      while (req_log.size() < 2 && n < 20) begin
         if (instr_valid === 1'b1) saw_valid = 1'b1;
         tick(1'b0, 16'h0, 1'b1);
         n++;
      end
      checks++;
      if (req_log.size() < 2 || req_log[0] !== 16'h0005 || req_log[1] !== 16'h0025) begin
         errors++; $display("FAIL drain_addr got %0d reqs %h %h exp 0005 0025", req_log.size(),
                            (req_log.size() > 0) ? req_log[0] : 16'hxxxx, (req_log.size() > 1) ? req_log[1] : 16'hxxxx);
      end
      checks++;
      if (saw_valid !== 1'b0) begin
         errors++; $display("FAIL drain_presented got %b exp 0", saw_valid);
      end
   endtask

   task automatic test_stall();
      logic [15:0] held_pc;
      ack_lo = 1; ack_hi = 1;
      reach_out();
      held_pc = owed[0];
      for (int i = 0; i < 5; i++) begin
         tick(1'b0, 16'h0, 1'b0);
         checks++;
         if (instr_pc !== held_pc || instr_data !== memf(held_pc) || imem_req !== 1'b0) begin
            errors++; $display("FAIL stall%0d got pc %h data %h req %b exp %h %h 0", i, instr_pc, instr_data, imem_req, held_pc, memf(held_pc));
         end
      end
      tick(1'b0, 16'h0, 1'b1);
   endtask

   task automatic test_reset_mid();
      int n = 0;
      ack_lo = 3; ack_hi = 3;
      while (!pending && n < 20) begin
         tick(1'b0, 16'h0, 1'b1);
         n++;
      end
      checks++;
      if (!pending) begin
         errors++; $display("FAIL reset_mid_setup got no request exp outstanding request");
      end
      do_reset(1'b1);
      ack_lo = 1; ack_hi = 1;
      req_log.delete();
      n = 0;
      while (req_log.size() < 1 && n < 10) begin
         tick(1'b0, 16'h0, 1'b1);
         n++;
      end
      checks++;
      if (req_log.size() < 1 || req_log[0] !== RV) begin
         errors++; $display("FAIL reset_mid_restart got %h exp %h", (req_log.size() > 0) ? req_log[0] : 16'hxxxx, RV);
      end
   endtask

   task automatic test_random();
      bit rd, rdy;
      logic [15:0] off;
      ack_lo = 0; ack_hi = 3;
      for (int i = 0; i < 3000; i++) begin
         rd  = ($urandom_range(11, 0) == 0);
         off = ($urandom_range(1, 0) == 0) ? 16'($urandom) : 16'($urandom_range(8, 0)) - 16'd4;
         rdy = ($urandom_range(2, 0) != 0);
         tick(rd, off, rdy);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired got no finish exp finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_sequential();
      test_wrap();
      test_redirect_out();
      test_redirect_drain();
      test_stall();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
